// File: rtl/mul_rs_pkg.sv
// Shared types and constants for the multiply reservation station.
//   RS_ENTRIES / RS_TAG_W : default station depth and ROB/CDB tag width
//   IDX_W                 : entry index width
//   MUL..MULHU            : op-select values carried in disp_op[8:7]
//   rs_entry_t            : one station entry
package mul_rs_pkg;

  localparam int RS_ENTRIES = 4;
  localparam int RS_TAG_W   = 4;
  localparam int IDX_W      = $clog2(RS_ENTRIES);

  localparam logic [1:0] MUL    = 2'b00;
  localparam logic [1:0] MULH   = 2'b01;
  localparam logic [1:0] MULHSU = 2'b10;
  localparam logic [1:0] MULHU  = 2'b11;

  typedef struct packed {
    logic                valid;
    logic [9:0]          op;
    logic [RS_TAG_W-1:0] tag;
    logic [31:0]         vj;
    logic [31:0]         vk;
    logic                qj_busy;
    logic [RS_TAG_W-1:0] qj;
    logic                qk_busy;
    logic [RS_TAG_W-1:0] qk;
  } rs_entry_t;

endpackage

// File: rtl/mul_rs_age_matrix.sv
// Age matrix for oldest-first selection.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : clears all age relations (flush)
//   alloc      : one-hot entry becoming youngest this cycle
//   free       : one-hot entry leaving this cycle
//   req        : entries requesting issue
//   grant      : one-hot oldest requester (combinational)
module mul_rs_age_matrix #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [N-1:0] alloc,
  input  logic [N-1:0] free,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  // older[i][j] = 1 means entry i was allocated before entry j
  logic [N-1:0] older [N];

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int i = 0; i < N; i++) older[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (alloc[i])
            older[i][j] <= 1'b0;        // newcomer is older than nobody
          else if (alloc[j])
            older[i][j] <= 1'b1;        // everyone else predates the newcomer
          else if (free[i] || free[j])
            older[i][j] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = req[i];
      for (int j = 0; j < N; j++)
        if (req[j] && older[j][i]) grant[i] = 1'b0;
    end
  end

endmodule

// File: rtl/mul_rs.sv
// Reservation station and issue scheduler for the combinational RV32M
// multiplier. Holds dispatched MUL-family ops, wakes pending operands from
// the CDB, issues the oldest ready entry and registers the product into a
// one-deep result slot drained by the CDB arbiter.
//   dispatch : disp_valid/disp_ready, disp_op/tag/vj/vk/qj_busy/qk_busy/qj/qk
//   cdb      : cdb_valid, cdb_tag, cdb_value
//   mult     : mul_vj, mul_vk, mul_op out; mul_y in
//   result   : res_valid/res_ready, res_tag, res_value
//   control  : clk, rst_n (sync, active-low), flush
module mul_rs #(
  parameter int ENTRIES = mul_rs_pkg::RS_ENTRIES,
  parameter int TAG_W   = mul_rs_pkg::RS_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [9:0]       disp_op,
  input  logic [TAG_W-1:0] disp_tag,
  input  logic [31:0]      disp_vj,
  input  logic [31:0]      disp_vk,
  input  logic             disp_qj_busy,
  input  logic             disp_qk_busy,
  input  logic [TAG_W-1:0] disp_qj,
  input  logic [TAG_W-1:0] disp_qk,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  output logic [31:0]      mul_vj,
  output logic [31:0]      mul_vk,
  output logic [9:0]       mul_op,
  input  logic [31:0]      mul_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [TAG_W-1:0] res_tag,
  output logic [31:0]      res_value
);
  import mul_rs_pkg::*;

  rs_entry_t ent [ENTRIES];

  logic [ENTRIES-1:0] valid_v, free_v, elig, alloc, req, grant;
  logic               disp_fire, can_issue, issue;
  logic               byp_j, byp_k;
  logic [TAG_W-1:0]   sel_tag;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      valid_v[i] = ent[i].valid;
      elig[i]    = ent[i].valid && !ent[i].qj_busy && !ent[i].qk_busy;
    end
  end

  assign free_v     = ~valid_v;
  assign disp_ready = rst_n && (|free_v);
  assign disp_fire  = disp_valid && disp_ready && !flush;
  // lowest set bit of free_v
  assign alloc      = disp_fire ? (free_v & (~free_v + {{(ENTRIES-1){1'b0}}, 1'b1})) : '0;

  assign byp_j = disp_qj_busy && cdb_valid && (cdb_tag == disp_qj);
  assign byp_k = disp_qk_busy && cdb_valid && (cdb_tag == disp_qk);

  assign can_issue = (|elig) && (!res_valid || res_ready) && !flush;
  assign req       = can_issue ? elig : '0;
  assign issue     = |grant;

  mul_rs_age_matrix #(.N(ENTRIES)) u_age (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .alloc (alloc),
    .free  (grant),
    .req   (req),
    .grant (grant)
  );

  always_comb begin
    mul_vj  = '0;
    mul_vk  = '0;
    mul_op  = '0;
    sel_tag = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (grant[i]) begin
        mul_vj  = ent[i].vj;
        mul_vk  = ent[i].vk;
        mul_op  = ent[i].op;
        sel_tag = ent[i].tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ent[i] <= '0;
      res_valid <= 1'b0;
      res_tag   <= '0;
      res_value <= '0;
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) ent[i].valid <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (grant[i]) begin
          ent[i].valid <= 1'b0;
        end else if (alloc[i]) begin
          ent[i].valid   <= 1'b1;
          ent[i].op      <= disp_op;
          ent[i].tag     <= disp_tag;
          ent[i].vj      <= byp_j ? cdb_value : disp_vj;
          ent[i].vk      <= byp_k ? cdb_value : disp_vk;
          ent[i].qj_busy <= disp_qj_busy && !byp_j;
          ent[i].qk_busy <= disp_qk_busy && !byp_k;
          ent[i].qj      <= disp_qj;
          ent[i].qk      <= disp_qk;
        end else if (ent[i].valid) begin
          if (ent[i].qj_busy && cdb_valid && (cdb_tag == ent[i].qj)) begin
            ent[i].vj      <= cdb_value;
            ent[i].qj_busy <= 1'b0;
          end
          if (ent[i].qk_busy && cdb_valid && (cdb_tag == ent[i].qk)) begin
            ent[i].vk      <= cdb_value;
            ent[i].qk_busy <= 1'b0;
          end
        end
      end
      if (issue) begin
        res_valid <= 1'b1;
        res_tag   <= sel_tag;
        res_value <= mul_y;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mul_rs.sv
module tb_mul_rs;

  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic        disp_valid, disp_ready;
  logic [9:0]  disp_op;
  logic [3:0]  disp_tag, disp_qj, disp_qk;
  logic [31:0] disp_vj, disp_vk;
  logic        disp_qj_busy, disp_qk_busy;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic [31:0] mul_vj, mul_vk, mul_y;
  logic [9:0]  mul_op;
  logic        res_valid, res_ready;
  logic [3:0]  res_tag;
  logic [31:0] res_value;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mul_rs dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_tag(disp_tag), .disp_vj(disp_vj), .disp_vk(disp_vk),
    .disp_qj_busy(disp_qj_busy), .disp_qk_busy(disp_qk_busy),
    .disp_qj(disp_qj), .disp_qk(disp_qk),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .mul_vj(mul_vj), .mul_vk(mul_vk), .mul_op(mul_op), .mul_y(mul_y),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_tag(res_tag), .res_value(res_value)
  );

  // combinational RV32M multiplier stand-in
  always_comb begin
    logic [63:0] p;
    case (mul_op[8:7])
      2'b00:   p = {32'b0, mul_vj} * {32'b0, mul_vk};
      2'b01:   p = {{32{mul_vj[31]}}, mul_vj} * {{32{mul_vk[31]}}, mul_vk};
      2'b10:   p = {{32{mul_vj[31]}}, mul_vj} * {32'b0, mul_vk};
      default: p = {32'b0, mul_vj} * {32'b0, mul_vk};
    endcase
    mul_y = (mul_op[8:7] == 2'b00) ? p[31:0] : p[63:32];
  end

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_disp(input logic [1:0] sel, input logic [31:0] vj, input logic [31:0] vk,
                         input logic [3:0] tag, input logic qjb, input logic [3:0] qj,
                         input logic qkb, input logic [3:0] qk);
    disp_valid   = 1'b1;
    disp_op      = {1'b0, sel, 7'b0110011};
    disp_vj      = vj;
    disp_vk      = vk;
    disp_tag     = tag;
    disp_qj_busy = qjb;
    disp_qj      = qj;
    disp_qk_busy = qkb;
    disp_qk      = qk;
    tick();
    disp_valid   = 1'b0;
    disp_qj_busy = 1'b0;
    disp_qk_busy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{2'b00, 32'd7,        32'd6,        4'd3,  32'd42};
    vecs[1] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd1,  32'h00000001};
    vecs[2] = '{2'b01, 32'hFFFFFFFE, 32'd3,        4'd2,  32'hFFFFFFFF};
    vecs[3] = '{2'b01, 32'h80000000, 32'h80000000, 4'd4,  32'h40000000};
    vecs[4] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd5,  32'hFFFFFFFF};
    vecs[5] = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd6,  32'hFFFFFFFE};
    vecs[6] = '{2'b10, 32'd2,        32'h80000000, 4'd7,  32'h00000001};
    vecs[7] = '{2'b11, 32'h00010000, 32'h00010000, 4'd8,  32'h00000001};
    vecs[8] = '{2'b00, 32'h12345678, 32'h00000010, 4'd15, 32'h23456780};

    rst_n = 1'b0; flush = 1'b0; disp_valid = 1'b0; disp_op = '0; disp_tag = '0;
    disp_vj = '0; disp_vk = '0; disp_qj_busy = 1'b0; disp_qk_busy = 1'b0;
    disp_qj = '0; disp_qk = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
    res_ready = 1'b1;

    // reset
    #1;
    check("rst_disp_ready_low", disp_ready, 0);
    tick(); tick();
    check("rst_res_valid", res_valid, 0);
    check("rst_res_tag", res_tag, 0);
    check("rst_res_value", res_value, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_disp_ready", disp_ready, 1);

    // table: ready dispatch, two-cycle latency, every op flavour
    for (int v = 0; v < 9; v++) begin
      do_disp(vecs[v].sel, vecs[v].vj, vecs[v].vk, vecs[v].tag, 1'b0, 4'd0, 1'b0, 4'd0);
      check($sformatf("vec%0d_not_yet", v), res_valid, 0);
      check($sformatf("vec%0d_mul_vj", v), mul_vj, vecs[v].vj);
      check($sformatf("vec%0d_mul_vk", v), mul_vk, vecs[v].vk);
      tick();
      check($sformatf("vec%0d_valid", v), res_valid, 1);
      check($sformatf("vec%0d_tag", v), res_tag, vecs[v].tag);
      check($sformatf("vec%0d_value", v), res_value, vecs[v].exp);
      tick();
      check($sformatf("vec%0d_drained", v), res_valid, 0);
    end

    // pending operand woken from the CDB
    do_disp(2'b11, 32'hFFFFFFFF, 32'd0, 4'd7, 1'b0, 4'd0, 1'b1, 4'd5);
    check("pend_no_issue0", mul_vj, 0);
    tick();
    cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_value = 32'hFFFFFFFF;
    #1;
    check("pend_no_issue1", mul_vj, 0);
    tick();
    cdb_valid = 1'b0;
    check("pend_no_same_cycle", res_valid, 0);
    check("pend_issue_vk", mul_vk, 32'hFFFFFFFF);
    tick();
    check("pend_valid", res_valid, 1);
    check("pend_tag", res_tag, 7);
    check("pend_value", res_value, 32'hFFFFFFFE);
    tick();
    check("pend_drained", res_valid, 0);

    // age order and back-pressure; C lands in a lower index than B
    res_ready = 1'b0;
    do_disp(2'b00, 32'd2, 32'd3, 4'd1, 1'b0, 4'd0, 1'b0, 4'd0);
    do_disp(2'b00, 32'd4, 32'd5, 4'd2, 1'b0, 4'd0, 1'b0, 4'd0);
    check("age_a_valid", res_valid, 1);
    check("age_a_tag", res_tag, 1);
    do_disp(2'b00, 32'd9, 32'd9, 4'd4, 1'b0, 4'd0, 1'b0, 4'd0);
    tick(); tick();
    check("age_a_held_tag", res_tag, 1);
    check("age_a_held_value", res_value, 6);
    res_ready = 1'b1;
    tick();
    check("age_b_valid", res_valid, 1);
    check("age_b_tag", res_tag, 2);
    check("age_b_value", res_value, 20);
    tick();
    check("age_c_valid", res_valid, 1);
    check("age_c_tag", res_tag, 4);
    check("age_c_value", res_value, 81);
    tick();
    check("age_drained", res_valid, 0);

    // dispatch bypass from a coincident CDB broadcast
    cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_value = 32'd3;
    do_disp(2'b01, 32'hFFFFFFFE, 32'd0, 4'd13, 1'b0, 4'd0, 1'b1, 4'd6);
    cdb_valid = 1'b0;
    check("byp_not_yet", res_valid, 0);
    tick();
    check("byp_valid", res_valid, 1);
    check("byp_tag", res_tag, 13);
    check("byp_value", res_value, 32'hFFFFFFFF);
    tick();
    check("byp_drained", res_valid, 0);

    // fill all four entries, dispatch while full is ignored, one tag wakes all
    do_disp(2'b00, 32'd1, 32'd0, 4'd8,  1'b0, 4'd0, 1'b1, 4'd9);
    do_disp(2'b00, 32'd2, 32'd0, 4'd9,  1'b0, 4'd0, 1'b1, 4'd9);
    do_disp(2'b00, 32'd3, 32'd0, 4'd10, 1'b0, 4'd0, 1'b1, 4'd9);
    do_disp(2'b00, 32'd0, 32'd0, 4'd11, 1'b1, 4'd9, 1'b1, 4'd9);
    check("full_disp_ready", disp_ready, 0);
    do_disp(2'b00, 32'd5, 32'd5, 4'd12, 1'b0, 4'd0, 1'b0, 4'd0);
    check("full_nothing_ready", res_valid, 0);
    cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_value = 32'd2;
    tick();
    cdb_valid = 1'b0;
    check("full_still_full", disp_ready, 0);
    tick();
    check("full_e0_tag", res_tag, 8);
    check("full_e0_value", res_value, 2);
    tick();
    check("full_e1_tag", res_tag, 9);
    check("full_e1_value", res_value, 4);
    tick();
    check("full_e2_tag", res_tag, 10);
    check("full_e2_value", res_value, 6);
    tick();
    check("full_e3_valid", res_valid, 1);
    check("full_e3_tag", res_tag, 11);
    check("full_e3_value", res_value, 4);
    tick();
    check("full_ignored_disp", res_valid, 0);

    // flush with three valid entries and a full result slot
    res_ready = 1'b0;
    do_disp(2'b00, 32'd1, 32'd1, 4'd1, 1'b0, 4'd0, 1'b0, 4'd0);
    do_disp(2'b00, 32'd2, 32'd2, 4'd2, 1'b0, 4'd0, 1'b0, 4'd0);
    do_disp(2'b00, 32'd3, 32'd3, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0);
    do_disp(2'b00, 32'd4, 32'd4, 4'd4, 1'b0, 4'd0, 1'b0, 4'd0);
    check("flush_pre_valid", res_valid, 1);
    check("flush_pre_tag", res_tag, 1);
    flush = 1'b1;
    do_disp(2'b00, 32'd5, 32'd5, 4'd5, 1'b0, 4'd0, 1'b0, 4'd0);
    flush = 1'b0;
    check("flush_res_valid", res_valid, 0);
    check("flush_disp_ready", disp_ready, 1);
    res_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("flush_no_issue%0d", c), res_valid, 0);
    end

    // synchronous reset mid-operation
    res_ready = 1'b0;
    do_disp(2'b00, 32'd3, 32'd3, 4'd5, 1'b0, 4'd0, 1'b0, 4'd0);
    do_disp(2'b00, 32'd4, 32'd0, 4'd6, 1'b0, 4'd0, 1'b1, 4'd14);
    check("mrst_pre_valid", res_valid, 1);
    check("mrst_pre_value", res_value, 9);
    rst_n = 1'b0;
    #1;
    check("mrst_disp_ready_low", disp_ready, 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("mrst_res_valid", res_valid, 0);
    check("mrst_res_tag", res_tag, 0);
    check("mrst_res_value", res_value, 0);
    check("mrst_disp_ready", disp_ready, 1);
    res_ready = 1'b1;
    cdb_valid = 1'b1; cdb_tag = 4'd14; cdb_value = 32'd7;
    tick();
    cdb_valid = 1'b0;
    tick(); tick();
    check("mrst_no_stale_issue", res_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_rs.md
Name: mul_rs

Overview:
- Reservation station and issue scheduler for the core's combinational RV32M multiplier.
- Accepts dispatched MUL/MULH/MULHSU/MULHU ops with ready or pending operands.
- Snoops the CDB to wake up pending operands, then issues the oldest ready entry to the multiplier.
- Registers the product into a one-deep result slot that the CDB arbiter drains with a valid/ready handshake.

Parameters:
- ENTRIES, 4, number of station entries (power of two, ≥2).
- TAG_W, 4, ROB/CDB tag width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- flush  in  1  pipeline flush (mispredict/exception).
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  free entry available.
- disp_op  in  10  decoded op; bits [8:7] select 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- disp_tag  in  TAG_W  destination tag.
- disp_vj / disp_vk  in  32  operand values.
- disp_qj_busy / disp_qk_busy  in  1  operand pending.
- disp_qj / disp_qk  in  TAG_W  producer tag when pending.
- cdb_valid  in  1  CDB broadcast.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_value  in  32  broadcast value.
- mul_vj / mul_vk  out  32  multiplier operands.
- mul_op  out  10  multiplier op.
- mul_y  in  32  multiplier result (combinational).
- res_valid  out  1  result slot full.
- res_ready  in  1  CDB arbiter accepts.
- res_tag  out  TAG_W  result tag.
- res_value  out  32  result value.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - all entries invalid, age matrix cleared;
  - res_valid=0, res_tag=0, res_value=0;
  - disp_ready=0 while rst_n=0, 1 from the first cycle after reset.
- Entry fields: valid, op, tag, vj, vk, qj_busy, qj, qk_busy, qk.
- disp_ready = OR of ~valid over entries (registered state only; a slot freed this cycle is not reusable until next cycle).
- Dispatch fires on disp_valid && disp_ready && !flush. Allocation goes to the lowest-index free entry, which becomes youngest in the age matrix.
- Dispatch bypass: if disp_qX_busy && cdb_valid && cdb_tag==disp_qX in the same cycle, store cdb_value and clear busy.
- Wakeup: each valid entry with qX_busy && cdb_valid && cdb_tag==qX latches cdb_value and clears busy at the edge. It becomes eligible next cycle (no same-cycle wakeup-to-issue).
- Eligible entry: valid && !qj_busy && !qk_busy.
- Issue condition: any eligible entry && (!res_valid || res_ready) && !flush.
- Selection: the oldest eligible entry per the ENTRIES×ENTRIES age matrix drives mul_vj/mul_vk/mul_op combinationally.
- When no entry issues, mul_* are driven to 0.
- At the issue edge:
  - res_tag←entry tag, res_value←mul_y, res_valid←1;
  - entry valid←0 and its age row/column are cleared.
- Handshake:
  - res_valid && res_ready with no issue → res_valid←0.
  - A drain and an issue in the same cycle → slot reloads, res_valid stays 1.
  - res_value/res_tag are held stable while res_valid && !res_ready.
- Minimum latency: dispatch with ready operands at edge N → issue in cycle N+1 → res_valid in cycle N+2.
- Width rules come from the multiplier:
  - MUL returns the low 32 bits.
  - MULH, MULHSU and MULHU return the high 32 bits of the signed×signed, signed×unsigned and unsigned×unsigned 64-bit product respectively.
  - The station does not alter operands.
- Flush:
  - all entries invalid and res_valid←0 at the next edge;
  - flush overrides dispatch, issue and wakeup in that cycle.
- Full: with all ENTRIES valid, disp_ready=0 and disp_valid is ignored.
- An entry cannot be freed and reallocated in the same cycle.
- A CDB tag matching both operands of one entry wakes both.

Decomposition:
- Package mul_rs_pkg holds:
  - op-select constants MUL=2'b00, MULH=2'b01, MULHSU=2'b10, MULHU=2'b11;
  - typedef rs_entry_t (struct of the entry fields);
  - localparam IDX_W = $clog2(ENTRIES).
- One natural sub-module, age_matrix. Inputs: allocate one-hot, free one-hot, request vector. Output: grant one-hot of the oldest requester.

Test Plan:
- Ready dispatch: Vj=7, Vk=6, MUL, tag 3, res_ready=1 → res_valid two cycles later, res_tag=3, res_value=42, res_valid low next cycle.
- Pending wakeup: dispatch MULHU with Vj=0xFFFFFFFF, qk_busy on tag 5; CDB tag 5 value 0xFFFFFFFF two cycles later → result 0xFFFFFFFE, issued only the cycle after the broadcast.
- Age order and back-pressure:
  - Dispatch A (tag 1) then B (tag 2), both ready, with res_ready=0 → A holds the slot and B waits.
  - Raise res_ready → A then B delivered consecutively, res_valid continuously high.
- Full/bypass:
  - Fill 4 entries pending → disp_ready=0.
  - CDB match coincident with a dispatch operand (MULH, Vj=-2, Vk via CDB=3) → stored value used, result 0xFFFFFFFF.
- Flush and reset:
  - Flush with 3 valid entries and res_valid=1 → next cycle res_valid=0, disp_ready=1, no later issue.
  - rst_n low for one edge mid-operation → same cleared state, with res_tag=0 and res_value=0.
